issue_stage: RTL
================

# issue_stage

Dispatch stage between the issue queue FIFO and the execution back-end. Each cycle it takes the head instruction from the issue queue, classifies it by major opcode, and allocates it in the reorder buffer and the matching reservation station in one atomic handshake. A three-state FSM serialises SYSTEM/MISC-MEM instructions and stops issue after an excepting instruction until the pipeline is flushed.

## Interface
- `XLEN`, default 64: data/address width.
- `ILEN`, default 32: instruction width.
- `ROB_IDX_LEN`, default 4: ROB index width.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset; asynchronous and active-high.
- `flush_i`  in  1  synchronous pipeline flush.
- `iq_valid_i` / `iq_ready_o`  in/out  1  handshake with the issue queue.
- `iq_curr_pc_i`  in  XLEN  instruction PC.
- `iq_instruction_i`  in  ILEN  instruction word.
- `iq_pred_target_i`  in  XLEN  predicted target.
- `iq_pred_taken_i`  in  1  predicted taken.
- `iq_except_raised_i`  in  1  fetch exception raised.
- `iq_except_code_i`  in  `len5_pkg::except_code_t`  fetch exception code.
- `rob_valid_o` / `rob_ready_i`  out/in  1  ROB allocation handshake.
- `rob_idx_i`  in  ROB_IDX_LEN  index the ROB assigns to the next allocation.
- `rob_empty_i`  in  1  ROB holds no instructions.
- `rob_pc_o`  out  XLEN  PC of the allocated instruction.
- `rob_res_ready_o`  out  1  entry is complete at allocation (exception path).
- `rob_except_raised_o`  out  1  exception flag.
- `rob_except_code_o`  out  except_code_t  exception code.
- `rs_valid_o` / `rs_ready_i`  out/in  4  one-hot per unit: [0] ALU, [1] BU, [2] LSU, [3] SYS.
- `rs_instruction_o`  out  ILEN  instruction to the reservation station.
- `rs_pc_o`  out  XLEN  PC to the reservation station.
- `rs_pred_target_o`  out  XLEN  predicted target.
- `rs_pred_taken_o`  out  1  predicted taken.
- `rs_rob_idx_o`  out  ROB_IDX_LEN  equals `rob_idx_i`.

## Operation
- **Classification** uses `instr[6:0]`:
  - ALU: 0110011, 0010011, 0111011, 0011011, 0110111, 0010111.
  - BU: 1100011, 1101111, 1100111.
  - LSU: 0000011, 0100011.
  - SYS: 1110011, 0001111.
  - Any other opcode, or `instr[1:0]` != 2'b11, is illegal with except code 2.
  - A fetch exception (`iq_except_raised_i`) takes priority over the illegal check and keeps `iq_except_code_i`.
- **Exception path**:
  - Dispatch goes to the ROB only, with `rob_res_ready_o`=1, `rob_except_raised_o`=1 and the code; `rs_valid_o`=0.
  - Fire = `iq_valid_i & rob_ready_i`.
- **Normal path** for class c:
  - Fire = `iq_valid_i & rob_ready_i & rs_ready_i[c]`.
  - `rob_valid_o`, `rs_valid_o[c]` and `iq_ready_o` all equal fire, so the ROB and the RS are never partially allocated.
  - `rob_res_ready_o`=0 and `rob_except_raised_o`=0.
- **SYS class** additionally requires `rob_empty_i`=1 to fire.
- **FSM states**, registered state only; all outputs are combinational from state and inputs (zero-latency pass-through):
  - NORMAL: dispatch as above. A fired exception goes to EXCEPT_STALL; a fired SYS goes to SERIAL_DRAIN.
  - SERIAL_DRAIN: all valids and `iq_ready_o` are 0. On the first cycle, unconditionally advance to a one-cycle guard (the ROB update is seen the next cycle). The guard then waits for `rob_empty_i`=1, then returns to NORMAL.
  - EXCEPT_STALL: all valids and `iq_ready_o` are 0 until `flush_i`.
  - Encode the states as NORMAL, SERIAL_GUARD, SERIAL_DRAIN, EXCEPT_STALL.
- **Flush**: `flush_i`=1 forces all valids and `iq_ready_o` to 0 that cycle, and the next state is NORMAL regardless of the current state. Flush has priority over every transition.
- **Reset**: state is NORMAL. `iq_ready_o`, `rob_valid_o` and `rs_valid_o` are 0 while `rst_i` is asserted. The data outputs pass through and have no reset value requirement. Asserting reset mid-stall returns the block to NORMAL.

## Timing
- Zero-cycle combinational path from `iq_*` to `rob_*`/`rs_*`, and from `*_ready_i` to `iq_ready_o`.
- Sustains one dispatch per cycle in NORMAL.
- Valids never depend on a ready they themselves feed; there are no combinational loops.
- SYS dispatch costs at least 2 stall cycles (guard plus drain) after firing.
- `iq_valid_i` held without a fire keeps the outputs stable.

## Test plan
- **Back-to-back ALU/LSU issue**: ADD (0x00B50533) then LW (0x0005A503), all readies 1.
  - Required: `rs_valid_o`=0001 then 0100 on consecutive cycles; `rs_rob_idx_o` tracks `rob_idx_i`=3,4.
- **Backpressure**: BEQ with `rs_ready_i[1]`=0 for 3 cycles, `rob_ready_i`=1.
  - Required: `rob_valid_o`=0 and `iq_ready_o`=0 for 3 cycles; fire on cycle 4.
- **Illegal instruction**: word 0x00000000.
  - Required: `rob_valid_o`=1, `rob_except_code_o`=2, `rob_res_ready_o`=1, `rs_valid_o`=0.
  - Then stall while `iq_valid_i` is held, until `flush_i`; NORMAL the next cycle.
- **Fetch exception priority**: `iq_except_raised_i`=1, code 1, valid ADD word.
  - Required: code 1 is dispatched, not ALU.
- **Serialisation**: CSRRW (0x30529073) with `rob_empty_i`=0 for 2 cycles.
  - Required: no fire until `rob_empty_i`=1. After the fire, the following ADD waits through the guard plus until `rob_empty_i` returns to 1.
- **Flush/reset during SERIAL_DRAIN**:
  - `flush_i` pulse: all valids 0 that cycle; NORMAL next.
  - Async `rst_i` mid-cycle: `iq_ready_o` drops immediately.

Source files
------------

// File: rtl/len5_pkg.sv
// Shared types for the LEN5 front-end/back-end boundary.
package len5_pkg;

  localparam int EXCEPT_TYPE_LEN = 4;

  typedef logic [EXCEPT_TYPE_LEN-1:0] except_code_t;

  // Exception codes follow the RISC-V mcause numbering.
  localparam except_code_t E_I_ADDR_MISALIGNED   = 4'd0;
  localparam except_code_t E_I_ACCESS_FAULT      = 4'd1;
  localparam except_code_t E_ILLEGAL_INSTRUCTION = 4'd2;

  // Reservation-station slots on the one-hot rs_valid_o / rs_ready_i vectors.
  localparam int UNIT_ALU = 0;
  localparam int UNIT_BU  = 1;
  localparam int UNIT_LSU = 2;
  localparam int UNIT_SYS = 3;

endpackage

// File: rtl/issue_stage.sv
// Issue stage: takes the head of the issue queue, classifies it by major
// opcode and allocates it atomically in the ROB and one reservation station.
// A small FSM serialises SYSTEM/MISC-MEM instructions and blocks issue after
// an excepting instruction until the pipeline is flushed.
module issue_stage
  import len5_pkg::*;
#(
  parameter int XLEN        = 64,
  parameter int ILEN        = 32,
  parameter int ROB_IDX_LEN = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,

  // Issue queue side
  input  logic                   iq_valid_i,
  output logic                   iq_ready_o,
  input  logic [XLEN-1:0]        iq_curr_pc_i,
  input  logic [ILEN-1:0]        iq_instruction_i,
  input  logic [XLEN-1:0]        iq_pred_target_i,
  input  logic                   iq_pred_taken_i,
  input  logic                   iq_except_raised_i,
  input  except_code_t           iq_except_code_i,

  // Reorder buffer side
  output logic                   rob_valid_o,
  input  logic                   rob_ready_i,
  input  logic [ROB_IDX_LEN-1:0] rob_idx_i,
  input  logic                   rob_empty_i,
  output logic [XLEN-1:0]        rob_pc_o,
  output logic                   rob_res_ready_o,
  output logic                   rob_except_raised_o,
  output except_code_t           rob_except_code_o,

  // Reservation stations side: [0] ALU, [1] BU, [2] LSU, [3] SYS
  output logic [3:0]             rs_valid_o,
  input  logic [3:0]             rs_ready_i,
  output logic [ILEN-1:0]        rs_instruction_o,
  output logic [XLEN-1:0]        rs_pc_o,
  output logic [XLEN-1:0]        rs_pred_target_o,
  output logic                   rs_pred_taken_o,
  output logic [ROB_IDX_LEN-1:0] rs_rob_idx_o
);

  // Major opcodes (instr[6:0])
  localparam logic [6:0] OP_OP        = 7'b0110011;
  localparam logic [6:0] OP_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP_32     = 7'b0111011;
  localparam logic [6:0] OP_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OP_LUI       = 7'b0110111;
  localparam logic [6:0] OP_AUIPC     = 7'b0010111;
  localparam logic [6:0] OP_BRANCH    = 7'b1100011;
  localparam logic [6:0] OP_JAL       = 7'b1101111;
  localparam logic [6:0] OP_JALR      = 7'b1100111;
  localparam logic [6:0] OP_LOAD      = 7'b0000011;
  localparam logic [6:0] OP_STORE     = 7'b0100011;
  localparam logic [6:0] OP_SYSTEM    = 7'b1110011;
  localparam logic [6:0] OP_MISC_MEM  = 7'b0001111;

  typedef enum logic [1:0] {
    NORMAL       = 2'd0,
    SERIAL_GUARD = 2'd1,
    SERIAL_DRAIN = 2'd2,
    EXCEPT_STALL = 2'd3
  } state_t;

  state_t       state;
  state_t       next_state;

  logic [3:0]   unit_sel;
  logic         illegal;
  logic         except_any;
  except_code_t except_code;
  logic         unit_ready;
  logic         sys_ok;
  logic         fire;

  // One-hot target unit for a major opcode; all zeros means no unit accepts it.
  function automatic logic [3:0] decode_unit(input logic [6:0] opcode);
    logic [3:0] sel;
    sel = 4'b0000;
    case (opcode)
      OP_OP, OP_OP_IMM, OP_OP_32, OP_OP_IMM_32, OP_LUI, OP_AUIPC:
        sel[UNIT_ALU] = 1'b1;
      OP_BRANCH, OP_JAL, OP_JALR:
        sel[UNIT_BU] = 1'b1;
      OP_LOAD, OP_STORE:
        sel[UNIT_LSU] = 1'b1;
      OP_SYSTEM, OP_MISC_MEM:
        sel[UNIT_SYS] = 1'b1;
      default:
        sel = 4'b0000;
    endcase
    return sel;
  endfunction

  // Classify the head instruction and resolve which exception, if any, it carries.
  always_comb begin
    unit_sel    = decode_unit(iq_instruction_i[6:0]);
    illegal     = (unit_sel == 4'b0000) || (iq_instruction_i[1:0] != 2'b11);
    // A fetch fault is older than the decode and keeps its own code.
    except_any  = iq_except_raised_i | illegal;
    except_code = iq_except_raised_i ? iq_except_code_i : E_ILLEGAL_INSTRUCTION;
    // Only the ready of the selected station matters; the valids never feed it.
    unit_ready  = |(unit_sel & rs_ready_i);
    sys_ok      = ~unit_sel[UNIT_SYS] | rob_empty_i;
  end

  // Dispatch handshake and next-state logic; one fire term drives every
  // valid/ready so the ROB and the RS are never partially allocated.
  always_comb begin
    fire       = 1'b0;
    iq_ready_o = 1'b0;
    rob_valid_o = 1'b0;
    rs_valid_o = 4'b0000;
    next_state = state;

    case (state)
      NORMAL: begin
        if (!flush_i && !rst_i) begin
          if (except_any) begin
            fire = iq_valid_i & rob_ready_i;
          end else begin
            fire = iq_valid_i & rob_ready_i & unit_ready & sys_ok;
          end
        end
        iq_ready_o  = fire;
        rob_valid_o = fire;
        rs_valid_o  = except_any ? 4'b0000 : (unit_sel & {4{fire}});
        if (fire) begin
          if (except_any) begin
            next_state = EXCEPT_STALL;
          end else if (unit_sel[UNIT_SYS]) begin
            next_state = SERIAL_DRAIN;
          end
        end
      end
      // The ROB only reflects the serialising instruction one cycle later,
      // so the first stall cycle never looks at rob_empty_i.
      SERIAL_DRAIN: begin
        next_state = SERIAL_GUARD;
      end
      SERIAL_GUARD: begin
        if (rob_empty_i) begin
          next_state = NORMAL;
        end
      end
      EXCEPT_STALL: begin
        next_state = EXCEPT_STALL;
      end
      default: begin
        next_state = NORMAL;
      end
    endcase

    if (flush_i) begin
      next_state = NORMAL;
    end
  end

  // State register; reset is asynchronous so a stall can be abandoned mid-cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= NORMAL;
    end else begin
      state <= next_state;
    end
  end

  // Data pass-through to ROB and reservation stations; only the valids qualify it.
  always_comb begin
    rob_pc_o            = iq_curr_pc_i;
    rob_res_ready_o     = except_any;
    rob_except_raised_o = except_any;
    rob_except_code_o   = except_any ? except_code : '0;
    rs_instruction_o    = iq_instruction_i;
    rs_pc_o             = iq_curr_pc_i;
    rs_pred_target_o    = iq_pred_target_i;
    rs_pred_taken_o     = iq_pred_taken_i;
    rs_rob_idx_o        = rob_idx_i;
  end

endmodule
